serial_mag_comparator: RTL and testbench
========================================

// Module: serial_mag_comparator
// PURPOSE
//  Sequential magnitude comparator: scans two WIDTH-bit words MSB->LSB, DIGIT bits per clock,
//  through a registered iterative-cell state (EQ/GT/LT). Successor of the combinational
//  left-to-right comparator network: parametrised width/digit, optional two's-complement
//  mode, start/done handshake, early termination. Sits beside the datapath as a shared,
//  area-cheap compare unit.
// PARAMETERS
//  WIDTH      16  operand width in bits; must be a multiple of DIGIT
//  DIGIT      1   bits examined per SCAN cycle (1, 2, 4, ... up to WIDTH)
//  SIGNED_EN  1   1: signed_mode input honoured; 0: signed_mode ignored, always unsigned
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-high reset
//  start        in   1      request; sampled only in IDLE
//  A            in   WIDTH  operand A, captured on accepted start
//  B            in   WIDTH  operand B, captured on accepted start
//  signed_mode  in   1      captured on accepted start; 1 = two's-complement compare
//  busy         out  1      high in SCAN and DONE
//  done         out  1      one-cycle pulse, result valid
//  eq/gt/lt     out  1 each registered result, one-hot, held until next accepted start
//  PQ           out  2      raw cell state: 01=EQ, 10=GT(A>B), 11=LT(A<B)
// BEHAVIOUR
//  - Reset (async, any state): FSM->IDLE, PQ=01, busy=0, done=0, eq=gt=lt=0, digit count=0.
//    Operation in flight is abandoned; no done pulse is produced for it.
//  - FSM: IDLE -start-> SCAN; SCAN -(last digit | PQ!=01)-> DONE; DONE -> IDLE (always, 1 cycle).
//  - Accepted start (IDLE, start=1 at edge k): latch A,B,signed_mode; PQ<=01; count<=0; eq/gt/lt<=0.
//  - SCAN cycle: cell takes PQ and the top DIGIT bits of A,B shift registers; next PQ:
//    from 01: equal digits->01, A digit>B digit->10, A digit<B digit->11; from 10/11: hold.
//    Shift registers move left by DIGIT; count++.
//  - Signed: on digit 0 only (signed_mode=1, SIGNED_EN=1) the sign bits are inverted on both
//    operands before the digit compare; remaining digits unsigned.
//  - Exit SCAN after the digit with count=WIDTH/DIGIT-1, or early after any digit yielding PQ!=01.
//  - DONE: done=1, eq/gt/lt decoded from PQ (01->eq, 10->gt, 11->lt); busy=1.
//  - Latency: start edge k -> done high in cycle k+n+1, n = digits scanned (1..WIDTH/DIGIT).
//    Back-to-back: next start accepted in the cycle after DONE (IDLE), throughput n+2 cycles.
//  - start during SCAN/DONE ignored (no queueing); A/B changes after capture have no effect.
//  - eq/gt/lt stay 0 between accepted start and done; exactly one is 1 after done.
//  - Count register width: clog2(WIDTH/DIGIT), min 1; wrap never occurs (exit at terminal).
// STRUCTURE
//  - cmp_pkg: localparams ST_EQ=2'b01, ST_GT=2'b10, ST_LT=2'b11; FSM encodings
//    S_IDLE/S_SCAN/S_DONE; function for count width.
//  - Sub-module digit_cmp_cell (combinational, parameter DIGIT): inputs PQ, a_dig, b_dig,
//    invert_msb; output next PQ. Top holds FSM, shift registers, counter, result regs.
// TESTING (WIDTH=8 unless noted)
//  1. A=0x5A,B=0x5A, unsigned, start at k -> 8 SCAN cycles, done@k+9, eq=1, PQ=01.
//  2. A=0x80,B=0x7F unsigned -> gt=1 after 1 digit (done@k+2); same with signed_mode=1 -> lt=1, done@k+2.
//  3. A=0x12,B=0x13 -> lt=1 at last digit, done@k+9; A=0xFF,B=0xFE signed -> gt=1 (-1>-2).
//  4. reset asserted at SCAN digit 3 -> outputs 0, PQ=01 immediately; no done; next start runs clean.
//  5. start held high and A/B toggled during SCAN -> ignored; result matches captured operands;
//     second start accepted only in IDLE, busy gaps of exactly 1 cycle.
//  6. DIGIT=4: A=0x5A,B=0x5B -> 2 SCAN cycles, lt=1; SIGNED_EN=0 with signed_mode=1, A=0x80,B=0x01 -> gt=1.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared encodings for the serial magnitude comparator.
// Cell-state codes, FSM states and counter sizing.
package cmp_pkg;

  localparam logic [1:0] ST_EQ = 2'b01;
  localparam logic [1:0] ST_GT = 2'b10;
  localparam logic [1:0] ST_LT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SCAN = 2'b01,
    S_DONE = 2'b10
  } state_t;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_cmp_cell.sv
// One iterative compare cell: folds a DIGIT-wide slice
// of A and B into the running EQ/GT/LT state.
module digit_cmp_cell
  import cmp_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [1:0]       pq,
  input  logic [DIGIT-1:0] a_dig,
  input  logic [DIGIT-1:0] b_dig,
  input  logic             invert_msb,
  output logic [1:0]       pq_nxt
);

  logic [DIGIT-1:0] flip;
  logic [DIGIT-1:0] a_x;
  logic [DIGIT-1:0] b_x;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  assign flip = DIGIT'(invert_msb) << (DIGIT - 1);
  assign a_x  = a_dig ^ flip;
  assign b_x  = b_dig ^ flip;

  // A decision already made is sticky; only an EQ state looks at the digit.
  always_comb begin
    pq_nxt = pq;
    if (pq == ST_EQ) begin
      unique case (1'b1)
        (a_x > b_x):  pq_nxt = ST_GT;
        (a_x < b_x):  pq_nxt = ST_LT;
        (a_x == b_x): pq_nxt = ST_EQ;
      endcase
    end
  end

endmodule

// File: rtl/serial_mag_comparator.sv
// Shared sequential magnitude comparator: scans A and B
// MSB first, DIGIT bits per clock, with early exit.
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIGIT     = 1,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [1:0]       PQ
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_w(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             sm;
  logic [CW-1:0]    cnt;
  logic [1:0]       pq_nxt;
  logic             inv;
  logic             fin;

  assign inv = sm && (cnt == '0);
  assign fin = (cnt == LAST) || (pq_nxt != ST_EQ);

  digit_cmp_cell #(
    .DIGIT(DIGIT)
  ) u_cell (
    .pq        (PQ),
    .a_dig     (a_sh[WIDTH-1 -: DIGIT]),
    .b_dig     (b_sh[WIDTH-1 -: DIGIT]),
    .invert_msb(inv),
    .pq_nxt    (pq_nxt)
  );

  // Control FSM with operand shifters, digit counter and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      PQ    <= ST_EQ;
      busy  <= 1'b0;
      done  <= 1'b0;
      eq    <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      sm    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            sm    <= signed_mode && (SIGNED_EN != 0);
            PQ    <= ST_EQ;
            cnt   <= '0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
            busy  <= 1'b1;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          PQ   <= pq_nxt;
          a_sh <= a_sh << DIGIT;
          b_sh <= b_sh << DIGIT;
          if (fin) begin
            state <= S_DONE;
            done  <= 1'b1;
            eq    <= (pq_nxt == ST_EQ);
            gt    <= (pq_nxt == ST_GT);
            lt    <= (pq_nxt == ST_LT);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench for serial_mag_comparator: three
// configurations share operands, each with its own queue.
module tb_serial_mag_comparator;

  typedef struct {
    logic [2:0] res;
    int         cyc;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             sm;
  logic [7:0]       a;
  logic [7:0]       b;
  logic [2:0]       st;
  logic [2:0]       busy;
  logic [2:0]       done;
  logic [2:0]       eq;
  logic [2:0]       gt;
  logic [2:0]       lt;
  logic [2:0][1:0]  pq;

  int   cyc  = 0;
  int   nvec = 0;
  int   nerr = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  serial_mag_comparator #(.WIDTH(8), .DIGIT(1), .SIGNED_EN(1)) u0 (
    .clk(clk), .reset(reset), .start(st[0]), .A(a), .B(b),
    .signed_mode(sm), .busy(busy[0]), .done(done[0]),
    .eq(eq[0]), .gt(gt[0]), .lt(lt[0]), .PQ(pq[0])
  );

  serial_mag_comparator #(.WIDTH(8), .DIGIT(4), .SIGNED_EN(1)) u1 (
    .clk(clk), .reset(reset), .start(st[1]), .A(a), .B(b),
    .signed_mode(sm), .busy(busy[1]), .done(done[1]),
    .eq(eq[1]), .gt(gt[1]), .lt(lt[1]), .PQ(pq[1])
  );

  serial_mag_comparator #(.WIDTH(8), .DIGIT(4), .SIGNED_EN(0)) u2 (
    .clk(clk), .reset(reset), .start(st[2]), .A(a), .B(b),
    .signed_mode(sm), .busy(busy[2]), .done(done[2]),
    .eq(eq[2]), .gt(gt[2]), .lt(lt[2]), .PQ(pq[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] pq_of(input logic [2:0] r);
    case (r)
      3'b100:  return 2'b01;
      3'b010:  return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic push(input int u, input exp_t e);
    case (u)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic check_done(input int u);
    exp_t       e;
    int         have;
    logic [2:0] r;
    have = 0;
    case (u)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
    endcase
    nvec++;
    r = {eq[u], gt[u], lt[u]};
    if (have == 0) begin
      nerr++;
      $display("FAIL u%0d unexpected done at cyc %0d", u, cyc);
    end else if (r != e.res || pq[u] != pq_of(e.res) ||
                 cyc != e.cyc || !busy[u]) begin
      nerr++;
      $display("FAIL u%0d result: eqgtlt=%b pq=%b cyc=%0d busy=%b want %b %b %0d 1",
               u, r, pq[u], cyc, busy[u], e.res, pq_of(e.res), e.cyc);
    end
  endtask

  // Monitor: pop on each done pulse; results must be clear while scanning.
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (done[u]) check_done(u);
      else if (busy[u]) chk($sformatf("u%0d res clear", u),
                            {eq[u], gt[u], lt[u]}, 0);
    end
  end

  task automatic wait_idle(input int u);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy[u]) return;
    end
    chk($sformatf("u%0d idle timeout", u), busy[u], 0);
  endtask

  task automatic go(input int u, input logic [7:0] av, input logic [7:0] bv,
                    input logic s, input int n, input logic [2:0] r);
    exp_t e;
    wait_idle(u);
    a = av;
    b = bv;
    sm = s;
    st[u] = 1'b1;
    @(posedge clk);
    #1;
    st[u] = 1'b0;
    e.res = r;
    e.cyc = cyc + n;
    push(u, e);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    st = '0;
    a = '0;
    b = '0;
    sm = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", busy[0], 0);
    chk("rst pq", pq[0], 2'b01);
    reset = 1'b0;
    @(negedge clk);
    chk("idle done", done[0], 0);
    chk("idle res", {eq[0], gt[0], lt[0]}, 0);

    go(0, 8'h5A, 8'h5A, 1'b0, 8, 3'b100);
    go(0, 8'h80, 8'h7F, 1'b0, 1, 3'b010);
    go(0, 8'h80, 8'h7F, 1'b1, 1, 3'b001);
    go(0, 8'h12, 8'h13, 1'b0, 8, 3'b001);
    go(0, 8'hFF, 8'hFE, 1'b1, 8, 3'b010);
    go(0, 8'h00, 8'hFF, 1'b1, 1, 3'b010);
    go(0, 8'h00, 8'hFF, 1'b0, 1, 3'b001);
    go(0, 8'h3C, 8'h34, 1'b0, 5, 3'b010);

    // Reset in the middle of a scan: abandoned, no done.
    wait_idle(0);
    a = 8'h5A;
    b = 8'h5A;
    sm = 1'b0;
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst busy", busy[0], 0);
    chk("midrst done", done[0], 0);
    chk("midrst res", {eq[0], gt[0], lt[0]}, 0);
    chk("midrst pq", pq[0], 2'b01);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    go(0, 8'h5A, 8'h5B, 1'b0, 8, 3'b001);

    // Start held high with operands churning during the scan.
    wait_idle(0);
    a = 8'h20;
    b = 8'h10;
    sm = 1'b0;
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    e.res = 3'b010;
    e.cyc = cyc + 3;
    push(0, e);
    for (int i = 0; i < 3; i++) begin
      a = 8'h00;
      b = 8'hFF - 8'(i);
      @(posedge clk);
      #1;
    end
    chk("hold busy done", busy[0], 1);
    @(posedge clk);
    #1;
    chk("hold busy gap", busy[0], 0);
    a = 8'h44;
    b = 8'h44;
    @(posedge clk);
    #1;
    chk("hold busy again", busy[0], 1);
    e.res = 3'b100;
    e.cyc = cyc + 8;
    push(0, e);
    st[0] = 1'b0;
    a = 8'h01;
    b = 8'h02;

    go(1, 8'h5A, 8'h5B, 1'b0, 2, 3'b001);
    go(1, 8'h80, 8'h01, 1'b1, 1, 3'b001);
    go(1, 8'h33, 8'h33, 1'b1, 2, 3'b100);
    go(1, 8'hF0, 8'h7F, 1'b0, 1, 3'b010);
    go(2, 8'h80, 8'h01, 1'b1, 1, 3'b010);
    go(2, 8'hFF, 8'hFE, 1'b1, 2, 3'b010);

    wait_idle(0);
    wait_idle(1);
    wait_idle(2);
    repeat (2) @(negedge clk);
    chk("q drained", q0.size() + q1.size() + q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
